// File: rtl/uart_tx_queue.sv
// Byte transmit queue in front of uart_hs: buffers upstream send strobes in a FIFO
// and replays them as single-cycle send pulses spaced exactly BYTE_CYCLES apart.
module uart_tx_queue #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned BYTE_CYCLES = 600
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  in_send,
  input  logic [7:0]            in_data,
  input  logic                  clr_overflow,
  output logic                  out_send,
  output logic [7:0]            out_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [15:0] GAP_LOAD = 16'(BYTE_CYCLES - 1);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  // The pop cycle is split into SEND (pulse high) and GAP so out_send decodes
  // straight from the state register and drops with the asynchronous reset.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic        in_send_last;
  logic        push, push_ok, pop;
  ptr_t        wr_ptr, rd_ptr;
  logic [15:0] gap_cnt;
  logic [7:0]  mem [DEPTH];

  assign push    = in_send && !in_send_last;
  assign full    = (count == cnt_t'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop     = (state_q == S_IDLE) && (count != '0);

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (pop) state_d = S_SEND;
      S_SEND, S_GAP: state_d = (gap_cnt == 16'd1) ? S_IDLE : S_GAP;
      default:      state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    out_send = (state_q == S_SEND);
  end

  // Storage array carries no reset.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      in_send_last <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_data     <= '0;
      gap_cnt      <= '0;
      overflow     <= 1'b0;
    end else begin
      in_send_last <= in_send;

      if (push_ok) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + ptr_t'(1);
        out_data <= mem[rd_ptr];
      end

      unique case ({push_ok, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase

      if (pop)                                  gap_cnt <= GAP_LOAD;
      else if (state_q != S_IDLE && gap_cnt != '0) gap_cnt <= gap_cnt - 16'd1;

      if (push && full)      overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue (DEPTH_LOG2=4, BYTE_CYCLES=600).
module tb_uart_tx_queue;

  localparam int B = 600;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       in_send = 1'b0;
  logic [7:0] in_data = '0;
  logic       clr_overflow = 1'b0;
  logic       out_send;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int width_err = 0;
  bit prev_send = 1'b0;
  int         pulse_cyc[$];
  logic [7:0] pulse_dat[$];

  uart_tx_queue #(.DEPTH_LOG2(4), .BYTE_CYCLES(B)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .in_send(in_send),
    .in_data(in_data),
    .clr_overflow(clr_overflow),
    .out_send(out_send),
    .out_data(out_data),
    .count(count),
    .empty(empty),
    .full(full),
    .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse monitor: samples on the falling edge, logs time and byte of each pulse.
  always @(negedge sys_clk) begin
    if (out_send) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(out_data);
      if (prev_send) width_err++;
    end
    prev_send = out_send;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    in_send = 1'b0;
    in_data = '0;
    clr_overflow = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    pulse_cyc.delete();
    pulse_dat.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_send !== 1'b0) begin failures++; $display("FAIL reset_out_send got=%b exp=0", out_send); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_single_byte();
    do_reset();
    in_send = 1'b1; in_data = 8'h41;       // cycle T
    @(negedge sys_clk); in_send = 1'b0;    // T+1
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL single_count_t1 got=%0d exp=1", count); end
    checks++; if (out_send !== 1'b0) begin failures++; $display("FAIL single_send_t1 got=%b exp=0", out_send); end
    @(negedge sys_clk);                    // T+2
    checks++; if (out_send !== 1'b1) begin failures++; $display("FAIL single_send_t2 got=%b exp=1", out_send); end
    checks++; if (out_data !== 8'h41) begin failures++; $display("FAIL single_data_t2 got=%h exp=41", out_data); end
    @(negedge sys_clk);                    // T+3
    checks++; if (out_send !== 1'b0) begin failures++; $display("FAIL single_send_t3 got=%b exp=0", out_send); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL single_count_t3 got=%0d exp=0", count); end
    checks++; if (out_data !== 8'h41) begin failures++; $display("FAIL single_data_hold got=%h exp=41", out_data); end
    repeat (2 * B) @(negedge sys_clk);
    checks++; if (pulse_dat.size() !== 1) begin failures++; $display("FAIL single_pulse_count got=%0d exp=1", pulse_dat.size()); end
  endtask

  task automatic test_burst();
    logic [7:0] exp_d;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_send = 1'b1; in_data = 8'h10 + 8'(k);
      @(negedge sys_clk); in_send = 1'b0;
      @(negedge sys_clk);
    end
    for (int i = 0; i < 3 * B && pulse_dat.size() < 3; i++) @(negedge sys_clk);
    repeat (B) @(negedge sys_clk);
    checks++; if (pulse_dat.size() !== 3) begin failures++; $display("FAIL burst_pulse_count got=%0d exp=3", pulse_dat.size()); end
    for (int i = 0; i < 3 && i < pulse_dat.size(); i++) begin
      exp_d = 8'h10 + 8'(i);
      checks++; if (pulse_dat[i] !== exp_d) begin failures++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, pulse_dat[i], exp_d); end
      if (i > 0) begin
        checks++; if (pulse_cyc[i] - pulse_cyc[i-1] !== B) begin failures++; $display("FAIL burst_spacing[%0d] got=%0d exp=%0d", i, pulse_cyc[i] - pulse_cyc[i-1], B); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      in_send = 1'b1; in_data = 8'(k);
      @(negedge sys_clk); in_send = 1'b0;
      @(negedge sys_clk);
    end
    checks++; if (pulse_dat.size() !== 1) begin failures++; $display("FAIL ovf_first_pop got=%0d exp=1", pulse_dat.size()); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count_full got=%0d exp=16", count); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_flag_early got=%b exp=0", overflow); end
    in_send = 1'b1; in_data = 8'h11;
    @(negedge sys_clk); in_send = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag_set got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count_kept got=%0d exp=16", count); end
    @(negedge sys_clk); clr_overflow = 1'b1;
    @(negedge sys_clk); clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_flag_clear got=%b exp=0", overflow); end
    for (int i = 0; i < 18 * B && pulse_dat.size() < 17; i++) @(negedge sys_clk);
    repeat (B + 10) @(negedge sys_clk);
    checks++; if (pulse_dat.size() !== 17) begin failures++; $display("FAIL ovf_pulse_count got=%0d exp=17", pulse_dat.size()); end
    for (int i = 0; i < 17 && i < pulse_dat.size(); i++) begin
      exp_d = 8'(i);
      checks++; if (pulse_dat[i] !== exp_d) begin failures++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, pulse_dat[i], exp_d); end
      if (i > 0) begin
        checks++; if (pulse_cyc[i] - pulse_cyc[i-1] !== B) begin failures++; $display("FAIL ovf_spacing[%0d] got=%0d exp=%0d", i, pulse_cyc[i] - pulse_cyc[i-1], B); end
      end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_drained_empty got=%b exp=1", empty); end
  endtask

  task automatic test_held_strobe();
    do_reset();
    in_send = 1'b1; in_data = 8'h55;
    @(negedge sys_clk);
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL held_count_t1 got=%0d exp=1", count); end
    repeat (4) @(negedge sys_clk);
    in_send = 1'b0;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL held_count_after got=%0d exp=0", count); end
    repeat (2 * B) @(negedge sys_clk);
    checks++; if (pulse_dat.size() !== 1) begin failures++; $display("FAIL held_pulse_count got=%0d exp=1", pulse_dat.size()); end
    if (pulse_dat.size() > 0) begin
      checks++; if (pulse_dat[0] !== 8'h55) begin failures++; $display("FAIL held_data got=%h exp=55", pulse_dat[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'hA1; exp_seq[1] = 8'hB2; exp_seq[2] = 8'hC3; exp_seq[3] = 8'hD4;
    do_reset();
    in_send = 1'b1; in_data = exp_seq[0];     // N0, popped at P2
    @(negedge sys_clk); in_send = 1'b0;       // N1
    @(negedge sys_clk); in_send = 1'b1; in_data = exp_seq[1];  // N2
    @(negedge sys_clk); in_send = 1'b0;       // N3
    @(negedge sys_clk); in_send = 1'b1; in_data = exp_seq[2];  // N4
    @(negedge sys_clk); in_send = 1'b0;       // N5
    repeat (595) @(negedge sys_clk);          // N600
    checks++; if (count !== 5'd2) begin failures++; $display("FAIL b2b_count_before got=%0d exp=2", count); end
    @(negedge sys_clk); in_send = 1'b1; in_data = exp_seq[3];  // N601, lands on pop edge P602
    @(negedge sys_clk); in_send = 1'b0;       // N602
    checks++; if (count !== 5'd2) begin failures++; $display("FAIL b2b_count_same got=%0d exp=2", count); end
    checks++; if (out_send !== 1'b1) begin failures++; $display("FAIL b2b_pop_pulse got=%b exp=1", out_send); end
    checks++; if (out_data !== exp_seq[1]) begin failures++; $display("FAIL b2b_pop_data got=%h exp=%h", out_data, exp_seq[1]); end
    for (int i = 0; i < 3 * B && pulse_dat.size() < 4; i++) @(negedge sys_clk);
    repeat (B + 10) @(negedge sys_clk);
    checks++; if (pulse_dat.size() !== 4) begin failures++; $display("FAIL b2b_pulse_count got=%0d exp=4", pulse_dat.size()); end
    for (int i = 0; i < 4 && i < pulse_dat.size(); i++) begin
      checks++; if (pulse_dat[i] !== exp_seq[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, pulse_dat[i], exp_seq[i]); end
    end
  endtask

  task automatic test_reset_mid_gap();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      in_send = 1'b1; in_data = 8'h60 + 8'(k);
      @(negedge sys_clk); in_send = 1'b0;
      @(negedge sys_clk);
    end
    repeat (90) @(negedge sys_clk);
    checks++; if (count !== 5'd4) begin failures++; $display("FAIL rgap_count_before got=%0d exp=4", count); end
    sys_rst = 1'b1;
    #1;
    checks++; if (out_send !== 1'b0) begin failures++; $display("FAIL rgap_out_send got=%b exp=0", out_send); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rgap_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rgap_empty got=%b exp=1", empty); end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    pulse_cyc.delete();
    pulse_dat.delete();
    repeat (2 * B) @(negedge sys_clk);
    checks++; if (pulse_dat.size() !== 0) begin failures++; $display("FAIL rgap_no_pulse got=%0d exp=0", pulse_dat.size()); end

    // Reset asserted while the pulse itself is high must drop it immediately.
    in_send = 1'b1; in_data = 8'h77;
    @(negedge sys_clk); in_send = 1'b0;
    @(negedge sys_clk);
    checks++; if (out_send !== 1'b1) begin failures++; $display("FAIL rpulse_pre got=%b exp=1", out_send); end
    sys_rst = 1'b1;
    #1;
    checks++; if (out_send !== 1'b0) begin failures++; $display("FAIL rpulse_out_send got=%b exp=0", out_send); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rpulse_out_data got=%h exp=00", out_data); end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    pulse_cyc.delete();
    pulse_dat.delete();
    repeat (2 * B) @(negedge sys_clk);
    checks++; if (pulse_dat.size() !== 0) begin failures++; $display("FAIL rpulse_no_pulse got=%0d exp=0", pulse_dat.size()); end
    checks++; if (width_err !== 0) begin failures++; $display("FAIL pulse_width got=%0d wide pulses exp=0", width_err); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_held_strobe();
    test_back_to_back();
    test_reset_mid_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte transmit queue between the UART command/MCU stage and the `uart_hs` transmitter. The upstream stage issues `uart_send`/`uart_data_w` strobes faster than the serial line can drain them, for example during SDRAM long-read dumps. This block buffers those strobes in a FIFO and replays them to `uart_hs` as single-cycle send pulses, spaced at least one byte-time apart. This removes the software-style `timer2` pacing from the upstream command logic.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).
- `BYTE_CYCLES`, default 600: minimum spacing, in `sys_clk` cycles, between consecutive `out_send` pulses. Legal range 2..65535.

- `sys_clk`  in  1  single clock; all logic on its rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `in_send`  in  1  upstream send strobe; a byte is pushed on its rising edge (low→high between consecutive cycles).
- `in_data`  in  8  byte to push; sampled in the same cycle the rising edge is detected.
- `clr_overflow`  in  1  synchronous clear of `overflow`.
- `out_send`  out  1  one-cycle send pulse to `uart_hs`.
- `out_data`  out  8  byte for `uart_hs`; valid while `out_send` is high and held until the next pulse.
- `count`  out  DEPTH_LOG2+1  number of bytes queued, excluding the byte currently in its gap.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == 2^DEPTH_LOG2`.
- `overflow`  out  1  sticky; set when a push is dropped.

## Operation
- **Edge detect:** an `in_send_last` register captures `in_send`. The push condition is `in_send && !in_send_last`, so a strobe held high for N cycles pushes exactly one byte.
- **FIFO storage:** register array of 2^DEPTH_LOG2 × 8, with write and read pointers of DEPTH_LOG2 bits.
  - Both pointers wrap modulo depth.
  - `count` is a separate DEPTH_LOG2+1-bit counter.
- **Push when not full:** write `mem[wr]`, increment `wr`, increment `count`.
- **Push when full:** the byte is dropped, pointers and `count` are unchanged, and `overflow` is set.
  - Fullness is judged on the registered `count`. A push in the same cycle as a pop while full is still dropped.
- **`overflow` flag:** cleared by reset or `clr_overflow`. If set and clear coincide, set wins.
- **FSM states:**
  - IDLE: if `count != 0`, pop. This means: `out_data <= mem[rd]`, `out_send <= 1`, increment `rd`, decrement `count`, load the gap counter, and go to GAP. Otherwise stay in IDLE.
  - GAP: `out_send <= 0`; the gap counter decrements each cycle. On expiry go to IDLE.
  - The gap counter is sized so that consecutive `out_send` rising edges are exactly BYTE_CYCLES cycles apart when the queue stays non-empty.
- **Simultaneous push and pop:** both take effect and `count` is unchanged.
- **Ordering:** strict FIFO; bytes leave in arrival order.

## Timing
- **Reset values:** `out_send=0`, `out_data=0`, `count=0`, `empty=1`, `full=0`, `overflow=0`, FSM=IDLE, gap counter=0, pointers=0, `in_send_last=0`. FIFO memory contents need not reset.
- **Reset mid-operation:** all queued bytes are discarded, `out_send` drops to 0 asynchronously, and no pulse follows until a new push.
- **Latency:** `in_send` is first high in cycle T with the queue empty and the FSM in IDLE.
  - T+1: `count` = 1.
  - T+2: `out_send` = 1 and `out_data` = the pushed byte.
  - T+3: `count` = 0.
- **Pulse width:** `out_send` is always exactly 1 cycle wide.
- **Spacing:** pulses are never closer than BYTE_CYCLES cycles apart, including when a push arrives while the FSM is in GAP.
- **Flag timing:** `empty`, `full` and `count` are registered or derived from registered `count`, and update the cycle after the push or pop edge.

## Test plan
- **Single byte:** reset, then in_send high 1 cycle with in_data=0x41. Expect `out_send` high in T+2 only, `out_data`=0x41, `count` back to 0, no further pulses for 2×BYTE_CYCLES.
- **Burst of 3:** with BYTE_CYCLES=600, push 0x10, 0x11, 0x12 on consecutive rising edges (in_send toggling). Expect three pulses 600 cycles apart, carrying 0x10, 0x11, 0x12 in order.
- **Overflow:** with the FSM held in GAP, push 18 bytes (0x00..0x11).
  - Expect 1 byte popped immediately, then `count` reaching 16 and `full`=1.
  - Expect the 18th push dropped and `overflow`=1.
  - Expect the later output sequence to be 0x00..0x10.
  - `clr_overflow` pulse → `overflow`=0.
- **Held strobe:** in_send high for 5 cycles with in_data=0x55. Expect exactly one byte queued and one pulse.
- **Simultaneous push and pop:** with 2 bytes queued, time a push to the IDLE pop cycle. Expect `count` to stay at 2 and all bytes to be output in order.
- **Reset mid-gap:** with 4 bytes queued, assert `sys_rst` 100 cycles into a gap. Expect immediate `out_send`=0, `count`=0, `empty`=1, and no pulses after release until a new push.
